// File: rtl/util_pack.sv
// Shared Benes network constants and types used by the permutation scheduler.
package util_pack;

  localparam int unsigned PACKAGE_STAGE_NUM  = 9;
  localparam int unsigned PACKAGE_SWITCH_NUM = 16;
  localparam int unsigned STAGE_W            = $clog2(PACKAGE_STAGE_NUM);

  typedef logic [PACKAGE_SWITCH_NUM-1:0] sw_word_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } slot_state_e;

endpackage

// File: rtl/benes_slot_tracker.sv
// Per-slot load-state FSM, written-stage mask, inflight count and write guard.
module benes_slot_tracker
  import util_pack::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [STAGE_W-1:0] wr_stage,
  input  logic               acc,
  input  logic               ret,
  output logic               ready,
  output logic               wr_ok_c
);

  localparam int unsigned CNT_W = 4;
  localparam logic [PACKAGE_STAGE_NUM-1:0] MASK_FULL = '1;

  slot_state_e                  state;
  logic [PACKAGE_STAGE_NUM-1:0] mask;
  logic [PACKAGE_STAGE_NUM-1:0] stage_bit;
  logic [PACKAGE_STAGE_NUM-1:0] mask_next;
  logic [CNT_W-1:0]             inflight;

  // A same-cycle accept on this slot takes priority over a reload
  always_comb begin
    stage_bit = PACKAGE_STAGE_NUM'(1) << wr_stage;
    mask_next = mask | stage_bit;
    wr_ok_c   = wr_en
              & (wr_stage <= STAGE_W'(PACKAGE_STAGE_NUM - 1))
              & (inflight == '0)
              & ~acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      mask     <= '0;
      ready    <= 1'b0;
      inflight <= '0;
    end else begin
      if (wr_ok_c) begin
        unique case (state)
          LOADING: begin
            mask <= mask_next;
            if (mask_next == MASK_FULL) begin
              state <= READY;
              ready <= 1'b1;
            end
          end
          default: begin
            mask  <= stage_bit;
            state <= LOADING;
            ready <= 1'b0;
          end
        endcase
      end
      if (acc && !ret) begin
        inflight <= inflight + CNT_W'(1);
      end else if (ret && !acc) begin
        inflight <= inflight - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/benes_sched_ctrl.sv
// Benes network sequencer: slot config memory, slot-tag pipeline and stream handshakes.
module benes_sched_ctrl
  import util_pack::*;
#(
  parameter int unsigned N_SLOT = 4,
  parameter int unsigned SLOT_W = $clog2(N_SLOT)
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 cfg_wr_en,
  input  logic [SLOT_W-1:0]                                    cfg_slot,
  input  logic [STAGE_W-1:0]                                   cfg_stage,
  input  logic [PACKAGE_SWITCH_NUM-1:0]                        cfg_bits,
  output logic                                                 cfg_err,
  output logic [N_SLOT-1:0]                                    slot_ready,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [SLOT_W-1:0]                                    in_slot,
  output logic [PACKAGE_STAGE_NUM-1:0]                         stage_en,
  output logic [PACKAGE_STAGE_NUM-1:0]                         stage_vld,
  output logic [PACKAGE_STAGE_NUM-1:0][PACKAGE_SWITCH_NUM-1:0] sw_ctrl,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [SLOT_W-1:0]                                    out_slot
);

  localparam int unsigned LAST = PACKAGE_STAGE_NUM - 1;

  sw_word_t                     cfg_mem [N_SLOT][PACKAGE_STAGE_NUM];
  logic [PACKAGE_STAGE_NUM-1:0] vld;
  logic [SLOT_W-1:0]            tag [PACKAGE_STAGE_NUM];
  logic [N_SLOT-1:0]            wr_ok;
  logic                         stall;
  logic                         accept;
  logic                         retire;

  for (genvar i = 0; i < N_SLOT; i++) begin : g_slot
    benes_slot_tracker u_trk (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (cfg_wr_en && (cfg_slot == SLOT_W'(i))),
      .wr_stage (cfg_stage),
      .acc      (accept && (in_slot == SLOT_W'(i))),
      .ret      (retire && (tag[LAST] == SLOT_W'(i))),
      .ready    (slot_ready[i]),
      .wr_ok_c  (wr_ok[i])
    );
  end

  // Handshake and global stall; the whole pipe freezes behind a blocked output
  always_comb begin
    stall     = vld[LAST] & ~out_ready;
    retire    = vld[LAST] & out_ready;
    in_ready  = ~stall & slot_ready[in_slot];
    accept    = in_valid & in_ready;
    stage_en  = {PACKAGE_STAGE_NUM{~stall}};
    stage_vld = vld;
    out_valid = vld[LAST];
    out_slot  = tag[LAST];
    for (int s = 0; s < PACKAGE_STAGE_NUM; s++) begin
      sw_ctrl[s] = vld[s] ? cfg_mem[tag[s]][s] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      for (int i = 0; i < N_SLOT; i++) begin
        for (int s = 0; s < PACKAGE_STAGE_NUM; s++) begin
          cfg_mem[i][s] <= '0;
        end
      end
    end else begin
      cfg_err <= cfg_wr_en & ~(|wr_ok);
      for (int i = 0; i < N_SLOT; i++) begin
        for (int s = 0; s < PACKAGE_STAGE_NUM; s++) begin
          if (wr_ok[i] && (cfg_stage == STAGE_W'(s))) begin
            cfg_mem[i][s] <= cfg_bits;
          end
        end
      end
    end
  end

  // Slot-tag pipeline tracking each vector through the network stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int s = 0; s < PACKAGE_STAGE_NUM; s++) begin
        tag[s] <= '0;
      end
    end else if (!stall) begin
      vld    <= {vld[LAST-1:0], accept};
      tag[0] <= in_slot;
      for (int s = 1; s < PACKAGE_STAGE_NUM; s++) begin
        tag[s] <= tag[s-1];
      end
    end
  end

endmodule

// File: tb/tb_benes_sched_ctrl.sv
// Directed bench for benes_sched_ctrl: slot loading, streaming, stall, guarded reload, reset.
module tb_benes_sched_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_wr_en;
  logic [1:0]        cfg_slot;
  logic [3:0]        cfg_stage;
  logic [15:0]       cfg_bits;
  logic              cfg_err;
  logic [3:0]        slot_ready;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_slot;
  logic [8:0]        stage_en;
  logic [8:0]        stage_vld;
  logic [8:0][15:0]  sw_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_slot;

  int n_checks = 0;
  int n_err    = 0;

  benes_sched_ctrl #(.N_SLOT(4), .SLOT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_slot   (cfg_slot),
    .cfg_stage  (cfg_stage),
    .cfg_bits   (cfg_bits),
    .cfg_err    (cfg_err),
    .slot_ready (slot_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_slot    (in_slot),
    .stage_en   (stage_en),
    .stage_vld  (stage_vld),
    .sw_ctrl    (sw_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_slot   (out_slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_sw_ctrl"},    32'(|sw_ctrl), 32'd0);
    check({pfx, "_stage_vld"},  32'(stage_vld), 32'd0);
    check({pfx, "_out_valid"},  32'(out_valid), 32'd0);
    check({pfx, "_out_slot"},   32'(out_slot), 32'd0);
    check({pfx, "_in_ready"},   32'(in_ready), 32'd0);
    check({pfx, "_slot_ready"}, 32'(slot_ready), 32'd0);
    check({pfx, "_cfg_err"},    32'(cfg_err), 32'd0);
    check({pfx, "_stage_en"},   32'(stage_en), 32'h1FF);
  endtask

  initial begin
    int n_ret;
    int k;
    logic stall_e;
    logic ov_e;

    rst_n     = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_slot  = '0;
    cfg_stage = '0;
    cfg_bits  = '0;
    in_valid  = 1'b0;
    in_slot   = '0;
    out_ready = 1'b1;
    #3;
    check_reset_outputs("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load slot 0 (one-hot rising) and slot 1 (one-hot falling)
    for (int sl = 0; sl < 2; sl++) begin
      for (int s = 0; s < 9; s++) begin
        cfg_wr_en = 1'b1;
        cfg_slot  = 2'(sl);
        cfg_stage = 4'(s);
        cfg_bits  = (sl == 0) ? (16'h0001 << s) : (16'h8000 >> s);
        tick();
        check("load_cfg_err", 32'(cfg_err), 32'd0);
        check("load_slot_ready", 32'(slot_ready[sl]), 32'(s == 8));
      end
    end

    // Out-of-range stage rejected, one-cycle pulse
    cfg_slot  = 2'd2;
    cfg_stage = 4'd9;
    cfg_bits  = 16'hFFFF;
    tick();
    check("bad_stage_err", 32'(cfg_err), 32'd1);
    check("bad_stage_ready", 32'(slot_ready), 32'h3);
    cfg_wr_en = 1'b0;
    tick();
    check("err_pulse_clear", 32'(cfg_err), 32'd0);

    // Single vector walks the pipe
    in_valid = 1'b1;
    in_slot  = 2'd0;
    #1;
    check("single_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int s = 0; s < 9; s++) begin
      check("single_stage_vld", 32'(stage_vld), 32'(9'b1 << s));
      check("single_sw_ctrl", 32'(sw_ctrl[s]), 32'(16'h0001 << s));
      check("single_out_valid", 32'(out_valid), 32'(s == 8));
      if (s < 8) tick();
    end
    check("single_out_slot", 32'(out_slot), 32'd0);
    tick();
    check("single_drained", 32'(stage_vld), 32'd0);

    // Stream 12 vectors alternating slots, output blocked cycles 12..15
    n_ret = 0;
    for (int c = 0; c < 27; c++) begin
      in_valid  = (c < 12);
      in_slot   = 2'(c % 2);
      out_ready = !(c >= 12 && c <= 15);
      #1;
      stall_e = (c >= 12 && c <= 15);
      ov_e    = (c >= 9 && c <= 24);
      check("strm_in_ready", 32'(in_ready), 32'(!stall_e));
      check("strm_stage_en", 32'(stage_en), stall_e ? 32'd0 : 32'h1FF);
      check("strm_out_valid", 32'(out_valid), 32'(ov_e));
      if (ov_e) begin
        k = (c <= 11) ? c - 9 : ((c <= 15) ? 3 : c - 13);
        check("strm_out_slot", 32'(out_slot), 32'(k % 2));
      end
      if (out_valid && out_ready) n_ret++;
      tick();
    end
    check("strm_retired", 32'(n_ret), 32'd12);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reload of slot 0 guarded while 3 vectors are in flight
    for (int c = 0; c < 13; c++) begin
      in_valid  = (c < 3);
      in_slot   = 2'd0;
      cfg_wr_en = (c == 3 || c == 12);
      cfg_slot  = 2'd0;
      cfg_stage = 4'd3;
      cfg_bits  = 16'hFFFF;
      tick();
      if (c == 3) begin
        check("guard_err", 32'(cfg_err), 32'd1);
        check("guard_mem_kept", 32'(sw_ctrl[3]), 32'h0008);
        check("guard_still_ready", 32'(slot_ready[0]), 32'd1);
      end
      if (c == 4) check("guard_err_clear", 32'(cfg_err), 32'd0);
      if (c == 12) begin
        check("reload_err", 32'(cfg_err), 32'd0);
        check("reload_loading", 32'(slot_ready[0]), 32'd0);
      end
    end
    cfg_wr_en = 1'b0;
    in_valid  = 1'b0;

    // Write and accept on slot 1 in the same cycle
    cfg_wr_en = 1'b1;
    cfg_slot  = 2'd1;
    cfg_stage = 4'd0;
    cfg_bits  = 16'hAAAA;
    in_valid  = 1'b1;
    in_slot   = 2'd1;
    #1;
    check("coll_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("coll_err", 32'(cfg_err), 32'd1);
    check("coll_stage_vld", 32'(stage_vld), 32'h001);
    check("coll_sw_ctrl", 32'(sw_ctrl[0]), 32'h8000);
    in_valid = 1'b0;
    tick();
    check("coll_inflight_err", 32'(cfg_err), 32'd1);
    check("coll_sw_ctrl1", 32'(sw_ctrl[1]), 32'h4000);
    cfg_wr_en = 1'b0;

    // Reset with vectors in flight
    in_valid = 1'b1;
    in_slot  = 2'd1;
    repeat (5) tick();
    in_valid = 1'b0;
    #1;
    check("pre_rst_vld", 32'(stage_vld), 32'h05F);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1;
    in_slot  = 2'd1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd0);
    check("post_rst_vld", 32'(stage_vld), 32'd0);
    in_valid = 1'b0;
    for (int s = 0; s < 9; s++) begin
      cfg_wr_en = 1'b1;
      cfg_slot  = 2'd2;
      cfg_stage = 4'(s);
      cfg_bits  = 16'h0F00 | 16'(s);
      tick();
    end
    cfg_wr_en = 1'b0;
    check("reload2_ready", 32'(slot_ready), 32'h4);
    in_slot = 2'd1;
    #1;
    check("reload2_slot1_blocked", 32'(in_ready), 32'd0);
    in_slot  = 2'd2;
    in_valid = 1'b1;
    #1;
    check("reload2_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("reload2_stage_vld", 32'(stage_vld), 32'h001);
    check("reload2_sw_ctrl", 32'(sw_ctrl[0]), 32'h0F00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
